// File: rtl/dlfloat_operand_tx.sv
// Host-side transmitter for the two-phase MAC operand bus.
// (A,B) DLFloat16 pairs are queued in a small FIFO. Each pair goes out on one
// 16-bit bus: A in even slots and B in odd slots. Slots free-run from reset.
module dlfloat_operand_tx #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] IDLE_WORD = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    output logic [15:0]              bus_out,
    output logic                     bus_phase,
    output logic                     bus_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              pairs_sent
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned WORD_W = 16;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } pair_t;

    // The slot state doubles as the bus phase: SLOT_A drives A, SLOT_B drives B.
    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } slot_e;

    slot_e              state_q, state_d;
    logic [WORD_W-1:0]  bus_out_q, bus_out_d;
    logic               bus_valid_q, bus_valid_d;
    logic [WORD_W-1:0]  hold_b_q, hold_b_d;
    logic [WORD_W-1:0]  pairs_sent_q, pairs_sent_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    pair_t              mem_q [DEPTH];
    pair_t              mem_d [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Next-state: slot alternation, pop at the B->A edge, push on handshake.
    always_comb begin
        state_d      = state_q;
        bus_out_d    = bus_out_q;
        bus_valid_d  = bus_valid_q;
        hold_b_d     = hold_b_q;
        pairs_sent_d = pairs_sent_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        mem_d        = mem_q;

        full  = (level_q == LVL_W'(DEPTH));
        empty = (level_q == '0);
        push  = in_valid && !full;
        pop   = 1'b0;

        case (state_q)
            SLOT_A: begin
                state_d   = SLOT_B;
                bus_out_d = hold_b_q;
            end
            SLOT_B: begin
                state_d = SLOT_A;
                if (bus_valid_q) begin
                    pairs_sent_d = pairs_sent_q + WORD_W'(1);
                end
                if (!empty) begin
                    pop         = 1'b1;
                    bus_out_d   = mem_q[rd_ptr_q].a;
                    hold_b_d    = mem_q[rd_ptr_q].b;
                    bus_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                end else begin
                    bus_out_d   = IDLE_WORD;
                    hold_b_d    = IDLE_WORD;
                    bus_valid_d = 1'b0;
                end
            end
            default: state_d = SLOT_A;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = '{a: in_a, b: in_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Control and bus registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SLOT_A;
            bus_out_q    <= IDLE_WORD;
            bus_valid_q  <= 1'b0;
            hold_b_q     <= '0;
            pairs_sent_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            bus_out_q    <= bus_out_d;
            bus_valid_q  <= bus_valid_d;
            hold_b_q     <= hold_b_d;
            pairs_sent_q <= pairs_sent_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // Pair storage; contents are don't-care until the pointers reference them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready   = !full;
    assign bus_out    = bus_out_q;
    assign bus_phase  = state_q;
    assign bus_valid  = bus_valid_q;
    assign fifo_level = level_q;
    assign pairs_sent = pairs_sent_q;

endmodule

// File: tb/tb_dlfloat_operand_tx.sv
// Scoreboard bench for dlfloat_operand_tx with a queue-based reference model.
module tb_dlfloat_operand_tx;

    localparam int unsigned DEPTH     = 4;
    localparam logic [15:0] IDLE_WORD = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] bus_out;
    logic        bus_phase;
    logic        bus_valid;
    logic [2:0]  fifo_level;
    logic [15:0] pairs_sent;

    dlfloat_operand_tx #(.DEPTH(DEPTH), .IDLE_WORD(IDLE_WORD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .bus_out    (bus_out),
        .bus_phase  (bus_phase),
        .bus_valid  (bus_valid),
        .fifo_level (fifo_level),
        .pairs_sent (pairs_sent)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: slot index since reset, queued pairs, expected words.
    bit          m_live = 1'b0;
    int          m_k = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_sent = '0;
    logic [31:0] m_fifo [$];
    logic [16:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: every edge ends one slot; odd slots end with a pop or idle fill.
    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_k     = 0;
            m_valid = 1'b0;
            m_sent  = '0;
            m_fifo.delete();
            sb.delete();
        end else if (m_live) begin
            bit acc;
            acc = in_valid && (m_fifo.size() < DEPTH);
            if ((m_k % 2) == 1) begin
                if (m_valid) m_sent = m_sent + 16'd1;
                if (m_fifo.size() > 0) begin
                    void'(m_fifo.pop_front());
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (acc) begin
                m_fifo.push_back({in_a, in_b});
                sb.push_back({1'b0, in_a});
                sb.push_back({1'b1, in_b});
            end
            m_k++;
        end
    end

    // Monitor: pops the scoreboard whenever the bus carries a real word.
    always @(negedge clk) begin
        if (m_live) begin
            logic [16:0] e;
            chk("phase", 32'(bus_phase), 32'(m_k % 2));
            chk("valid", 32'(bus_valid), 32'(m_valid));
            chk("level", 32'(fifo_level), 32'(m_fifo.size()));
            chk("in_ready", 32'(in_ready), 32'(m_fifo.size() != DEPTH));
            chk("pairs_sent", 32'(pairs_sent), 32'(m_sent));
            if (bus_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(bus_out), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("word", 32'(bus_out), 32'(e[15:0]));
                    chk("word_phase", 32'(bus_phase), 32'(e[16]));
                end
            end else begin
                chk("idle_word", 32'(bus_out), 32'(IDLE_WORD));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one pair and hold it until the edge that accepts it.
    task automatic push_one(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (m_fifo.size() >= DEPTH && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
        cycle();
        in_valid = 1'b0;
        in_a = $urandom();
        in_b = $urandom();
    endtask

    task automatic wait_parity(input int par);
        int n;
        n = 0;
        while ((m_k % 2) != par && n < 4) begin
            cycle();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int n;
        cycle();
        do_reset();
        drain(8);

        // Push lands on an A->B edge: one-cycle latency.
        wait_parity(0);
        push_one(16'h3E00, 16'h4000);
        drain(6);

        // Push lands on a B->A edge: one idle B slot first.
        wait_parity(1);
        push_one(16'h3E00, 16'h4000);
        drain(6);

        // Six back-to-back pairs against a depth-4 FIFO.
        for (int i = 0; i < 6; i++) push_one(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        drain(16);

        // Reset during the B slot of the second of three queued pairs.
        do_reset();
        for (int i = 0; i < 3; i++) push_one(16'h7C00 + 16'(i), 16'h8001 + 16'(i));
        n = 0;
        while (!(m_sent == 16'd1 && m_valid && (m_k % 2) == 1) && n < 50) begin
            cycle();
            n++;
        end
        chk("mid_pair_found", 32'(n < 50), 32'd1);
        do_reset();
        drain(6);

        // Randomized traffic including special DLFloat patterns.
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       in_a = 16'h7FFF;
                1:       in_a = 16'h0001;
                default: in_a = 16'($urandom());
            endcase
            in_b = 16'($urandom());
            cycle();
        end
        in_valid = 1'b0;
        drain(20);

        // Counter wrap from FFFF.
        n = 0;
        while ((m_fifo.size() != 0 || m_valid) && n < 50) begin
            cycle();
            n++;
        end
        force dut.pairs_sent_q = 16'hFFFF;
        m_sent = 16'hFFFF;
        #1;
        release dut.pairs_sent_q;
        cycle();
        push_one(16'h3C00, 16'hBC00);
        drain(8);
        chk("wrapped", 32'(m_sent), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
